// File: rtl/jesd_rx_pkg.sv
// Shared link-layer constants for the JESD204 receive controller:
// state encodings, control-character codes and link thresholds.
package jesd_rx_pkg;

  typedef enum logic [3:0] {
    CS_INIT = 4'b0001,
    CS_WAIT = 4'b0010,
    ILA     = 4'b0100,
    DATA    = 4'b1000
  } link_state_t;

  localparam logic [7:0] K28_5 = 8'hBC;  // /K/ comma
  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config start

  localparam int CGS_THRESHOLD = 4;
  localparam int ERR_THRESHOLD = 3;
  localparam int CLEAN_RUN     = 4;

  function automatic logic is_k_char(
    input logic       valid,
    input logic       is_k,
    input logic [7:0] octet,
    input logic [7:0] code
  );
    return valid && is_k && (octet == code);
  endfunction

endpackage

// File: rtl/rx_err_monitor.sv
// DATA-state error supervision: a short error window that trips a relink,
// and a saturating software-visible error counter.
module rx_err_monitor
  import jesd_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       active,
  input  logic       valid,
  input  logic       errored,
  input  logic       err_cnt_clr,
  output logic       trip,
  output logic [7:0] err_cnt
);

  logic [1:0] win_err;
  logic [1:0] clean_run;

  // The error that would make the window reach the threshold trips the link.
  assign trip = active && errored && (win_err == 2'(ERR_THRESHOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_err   <= '0;
      clean_run <= '0;
      err_cnt   <= '0;
    end else begin
      if (clear || !active) begin
        win_err   <= '0;
        clean_run <= '0;
      end else if (errored) begin
        clean_run <= '0;
        win_err   <= trip ? 2'd0 : win_err + 2'd1;
      end else if (valid) begin
        if (clean_run == 2'(CLEAN_RUN - 1)) begin
          win_err   <= '0;
          clean_run <= '0;
        end else begin
          clean_run <= clean_run + 2'd1;
        end
      end

      // Software clear takes priority over a same-cycle increment.
      if (err_cnt_clr) begin
        err_cnt <= '0;
      end else if (active && errored && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/rx_control.sv
// JESD204 receive link controller: code-group sync, ILA sequencing and
// DATA hand-off, with SYNC~ generation towards the transmitter.
module rx_control
  import jesd_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_clk,
  input  logic       lmfc_clk,
  input  logic       i_valid,
  input  logic [7:0] i_octet,
  input  logic       i_is_k,
  input  logic       i_disp_err,
  input  logic       i_nit_err,
  input  logic [7:0] i_ila_multiframe_length,
  input  logic       i_reg_resync,
  input  logic       i_err_cnt_clr,
  output logic       o_sync_n,
  output logic [3:0] o_link_state,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic [7:0] o_err_cnt,
  output logic [7:0] o_ila_frame_cnt
);

  link_state_t state;
  logic [2:0]  cgs_cnt;
  logic [8:0]  mf_cnt;
  logic        seen_r;

  logic        good_k;
  logic        errored;
  logic        is_r;
  logic        is_a;
  logic        in_data;
  logic        trip;
  logic        last_k;
  logic        last_a;
  logic [8:0]  mf_target;

  assign errored   = i_valid && (i_disp_err || i_nit_err);
  assign good_k    = is_k_char(i_valid, i_is_k, i_octet, K28_5) && !i_disp_err && !i_nit_err;
  assign is_r      = is_k_char(i_valid, i_is_k, i_octet, K28_0);
  assign is_a      = is_k_char(i_valid, i_is_k, i_octet, K28_3);
  assign in_data   = (state == DATA);
  // Length is encoded value-1; the 9-bit sum lets 8'hFF mean 256 multiframes.
  assign mf_target = {1'b0, i_ila_multiframe_length} + 9'd1;
  assign last_k    = (cgs_cnt == 3'(CGS_THRESHOLD - 1));
  assign last_a    = ((mf_cnt + 9'd1) == mf_target);

  assign o_link_state = state;

  rx_err_monitor u_err_monitor (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (i_reg_resync),
    .active      (in_data),
    .valid       (i_valid),
    .errored     (errored),
    .err_cnt_clr (i_err_cnt_clr),
    .trip        (trip),
    .err_cnt     (o_err_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= CS_INIT;
      cgs_cnt         <= '0;
      mf_cnt          <= '0;
      seen_r          <= 1'b0;
      o_ila_frame_cnt <= '0;
      o_sync_n        <= 1'b0;
      o_data          <= '0;
      o_data_valid    <= 1'b0;
    end else begin
      // Outputs follow the state already held, giving one cycle of latency.
      o_sync_n     <= (state == ILA) || (state == DATA);
      o_data       <= i_octet;
      o_data_valid <= i_valid && in_data && !trip && !i_reg_resync;

      if (i_reg_resync) begin
        state           <= CS_INIT;
        cgs_cnt         <= '0;
        mf_cnt          <= '0;
        seen_r          <= 1'b0;
        o_ila_frame_cnt <= '0;
      end else begin
        case (state)
          CS_INIT: begin
            if (good_k) begin
              if (last_k) begin
                state   <= CS_WAIT;
                cgs_cnt <= '0;
              end else begin
                cgs_cnt <= cgs_cnt + 3'd1;
              end
            end else if (i_valid) begin
              cgs_cnt <= '0;
            end
          end

          // Entered only on the cycle after the 4th /K/, so a coincident
          // LMFC pulse is never seen here.
          CS_WAIT: begin
            if (lmfc_clk) begin
              state  <= ILA;
              mf_cnt <= '0;
              seen_r <= 1'b0;
            end
          end

          ILA: begin
            if (frame_clk) begin
              o_ila_frame_cnt <= o_ila_frame_cnt + 8'd1;
            end
            if (errored || (i_valid && !good_k && !seen_r && !is_r)) begin
              state           <= CS_INIT;
              mf_cnt          <= '0;
              seen_r          <= 1'b0;
              o_ila_frame_cnt <= '0;
            end else if (!seen_r && is_r) begin
              seen_r <= 1'b1;
            end else if (seen_r && is_a) begin
              if (last_a) begin
                state           <= DATA;
                mf_cnt          <= '0;
                seen_r          <= 1'b0;
                o_ila_frame_cnt <= '0;
              end else begin
                mf_cnt <= mf_cnt + 9'd1;
              end
            end
          end

          DATA: begin
            if (trip) begin
              state <= CS_INIT;
            end
          end

          default: state <= CS_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_control.sv
// Self-checking bench for rx_control: directed link bring-up scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_rx_control;
  import jesd_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       lmfc_clk = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_octet = 8'h00;
  logic       i_is_k = 1'b0;
  logic       i_disp_err = 1'b0;
  logic       i_nit_err = 1'b0;
  logic [7:0] i_ila_multiframe_length = 8'h00;
  logic       i_reg_resync = 1'b0;
  logic       i_err_cnt_clr = 1'b0;
  logic       o_sync_n;
  logic [3:0] o_link_state;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic [7:0] o_err_cnt;
  logic [7:0] o_ila_frame_cnt;

  int n_checks = 0;
  int n_fail = 0;

  logic g_lmfc = 1'b0, g_fclk = 1'b0, g_rs = 1'b0, g_clr = 1'b0;

  // Model: link phase index 0=init 1=wait 2=ila 3=data
  int   m_st, m_runs, m_mf, m_errs, m_clean, m_cnt, m_frame;
  bit   m_seen;
  logic exp_sync, exp_dv;
  logic [7:0] exp_data;

  rx_control dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .frame_clk               (frame_clk),
    .lmfc_clk                (lmfc_clk),
    .i_valid                 (i_valid),
    .i_octet                 (i_octet),
    .i_is_k                  (i_is_k),
    .i_disp_err              (i_disp_err),
    .i_nit_err               (i_nit_err),
    .i_ila_multiframe_length (i_ila_multiframe_length),
    .i_reg_resync            (i_reg_resync),
    .i_err_cnt_clr           (i_err_cnt_clr),
    .o_sync_n                (o_sync_n),
    .o_link_state            (o_link_state),
    .o_data                  (o_data),
    .o_data_valid            (o_data_valid),
    .o_err_cnt               (o_err_cnt),
    .o_ila_frame_cnt         (o_ila_frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] phase_onehot(input int s);
    return 4'(1 << s);
  endfunction

  task automatic model_reset();
    m_st = 0; m_runs = 0; m_mf = 0; m_errs = 0; m_clean = 0; m_cnt = 0; m_frame = 0;
    m_seen = 0; exp_sync = 1'b0; exp_dv = 1'b0; exp_data = 8'h00;
  endtask

  task automatic model_step();
    bit good, err, trip;
    int target;
    good   = i_valid && i_is_k && (i_octet == 8'hBC) && !i_disp_err && !i_nit_err;
    err    = i_valid && (i_disp_err || i_nit_err);
    target = int'(i_ila_multiframe_length) + 1;
    trip   = (m_st == 3) && err && (m_errs == 2);
    exp_sync = (m_st >= 2);
    exp_data = i_octet;
    exp_dv   = i_valid && (m_st == 3) && !trip && !i_reg_resync;
    if (i_err_cnt_clr) m_cnt = 0;
    else if ((m_st == 3) && err && (m_cnt < 255)) m_cnt = m_cnt + 1;
    if ((m_st == 3) && !i_reg_resync) begin
      if (err) begin
        m_clean = 0;
        m_errs = trip ? 0 : m_errs + 1;
      end else if (i_valid) begin
        m_clean = m_clean + 1;
        if (m_clean == 4) begin m_errs = 0; m_clean = 0; end
      end
    end else begin
      m_errs = 0; m_clean = 0;
    end
    if ((m_st == 2) && frame_clk && !i_reg_resync) m_frame = (m_frame + 1) % 256;
    if (i_reg_resync) begin
      m_st = 0; m_runs = 0; m_mf = 0; m_seen = 0;
    end else begin
      case (m_st)
        0: if (good) begin
             m_runs = m_runs + 1;
             if (m_runs == 4) begin m_st = 1; m_runs = 0; end
           end else if (i_valid) m_runs = 0;
        1: if (lmfc_clk) begin m_st = 2; m_mf = 0; m_seen = 0; end
        2: if (err) m_st = 0;
           else if (i_valid && !good) begin
             if (!m_seen) begin
               if (i_is_k && (i_octet == 8'h1C)) m_seen = 1; else m_st = 0;
             end else if (i_is_k && (i_octet == 8'h7C)) begin
               m_mf = m_mf + 1;
               if (m_mf == target) m_st = 3;
             end
           end
        default: if (trip) m_st = 0;
      endcase
    end
    if (m_st != 2) m_frame = 0;
  endtask

  task automatic tick(input logic v, input logic [7:0] oct, input logic k, input logic de, input logic nit);
    i_valid = v; i_octet = oct; i_is_k = k; i_disp_err = de; i_nit_err = nit;
    lmfc_clk = g_lmfc; frame_clk = g_fclk; i_reg_resync = g_rs; i_err_cnt_clr = g_clr;
    @(posedge clk);
    model_step();
    #1;
    g_lmfc = 0; g_fclk = 0; g_rs = 0; g_clr = 0;
    lmfc_clk = 0; frame_clk = 0; i_reg_resync = 0; i_err_cnt_clr = 0;
  endtask

  task automatic send_k(input logic [7:0] c); tick(1'b1, c, 1'b1, 1'b0, 1'b0); endtask
  task automatic send_d(input logic [7:0] d); tick(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic send_err(); tick(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0); endtask
  task automatic idle(); tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic bring_to_ila(input int len);
    i_ila_multiframe_length = 8'(len);
    repeat (4) send_k(K28_5);
    g_lmfc = 1'b1;
    idle();
  endtask

  task automatic bring_to_data(input int len);
    bring_to_ila(len);
    send_k(K28_0);
    repeat (len + 1) send_k(K28_3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o_link_state !== 4'b0001) begin n_fail++; $display("FAIL reset_state: got %b want 0001", o_link_state); end
    n_checks++; if (o_sync_n !== 1'b0) begin n_fail++; $display("FAIL reset_sync_n: got %b want 0", o_sync_n); end
    n_checks++; if (o_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b want 0", o_data_valid); end
    n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", o_data); end
    n_checks++; if (o_err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", o_err_cnt); end
    n_checks++; if (o_ila_frame_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", o_ila_frame_cnt); end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_cgs();
    apply_reset();
    repeat (3) send_k(K28_5);
    n_checks++; if (o_link_state !== 4'b0001) begin n_fail++; $display("FAIL cgs_3k: got %b want 0001", o_link_state); end
    g_lmfc = 1'b1;
    send_k(K28_5);
    n_checks++; if (o_link_state !== 4'b0010) begin n_fail++; $display("FAIL cgs_4k: got %b want 0010", o_link_state); end
    for (int i = 0; i < 9; i++) begin
      idle();
      n_checks++; if (o_link_state !== 4'b0010 || o_sync_n !== 1'b0) begin n_fail++; $display("FAIL cgs_wait[%0d]: state %b sync %b want 0010/0", i, o_link_state, o_sync_n); end
    end
    g_lmfc = 1'b1;
    idle();
    n_checks++; if (o_link_state !== 4'b0100 || o_sync_n !== 1'b0) begin n_fail++; $display("FAIL cgs_lmfc: state %b sync %b want 0100/0", o_link_state, o_sync_n); end
    idle();
    n_checks++; if (o_sync_n !== 1'b1) begin n_fail++; $display("FAIL cgs_sync_rise: got %b want 1", o_sync_n); end
    apply_reset();
    repeat (3) send_k(K28_5);
    send_d(8'h55);
    repeat (3) send_k(K28_5);
    n_checks++; if (o_link_state !== 4'b0001) begin n_fail++; $display("FAIL cgs_broken_run: got %b want 0001", o_link_state); end
    send_k(K28_5);
    n_checks++; if (o_link_state !== 4'b0010) begin n_fail++; $display("FAIL cgs_second_run: got %b want 0010", o_link_state); end
    $display("test_cgs done");
  endtask

  task automatic test_ila();
    logic       v;
    logic [7:0] d;
    apply_reset();
    bring_to_ila(3);
    n_checks++; if (o_link_state !== 4'b0100) begin n_fail++; $display("FAIL ila_enter: got %b want 0100", o_link_state); end
    repeat (2) send_k(K28_5);
    send_k(K28_0);
    for (int mf = 0; mf < 4; mf++) begin
      repeat (3) send_d(8'($urandom));
      send_k(K28_3);
      n_checks++;
      if (o_link_state !== ((mf < 3) ? 4'b0100 : 4'b1000)) begin
        n_fail++; $display("FAIL ila_mf[%0d]: got %b want %b", mf, o_link_state, (mf < 3) ? 4'b0100 : 4'b1000);
      end
    end
    for (int i = 0; i < 16; i++) begin
      v = 1'($urandom);
      d = 8'($urandom);
      send_d(d);
      if (!v) begin
        // replace with an idle cycle half the time
      end
      tick(v, d, 1'b0, 1'b0, 1'b0);
      n_checks++; if (o_data_valid !== v) begin n_fail++; $display("FAIL ila_dv_follow[%0d]: got %b want %b", i, o_data_valid, v); end
      if (v) begin
        n_checks++; if (o_data !== d) begin n_fail++; $display("FAIL ila_data[%0d]: got %h want %h", i, o_data, d); end
      end
    end
    apply_reset();
    bring_to_ila(2);
    send_d(8'h55);
    n_checks++; if (o_link_state !== 4'b0001) begin n_fail++; $display("FAIL ila_no_r: got %b want 0001", o_link_state); end
    apply_reset();
    bring_to_ila(2);
    send_k(K28_0);
    tick(1'b1, K28_3, 1'b1, 1'b0, 1'b1);
    n_checks++; if (o_link_state !== 4'b0001) begin n_fail++; $display("FAIL ila_errored: got %b want 0001", o_link_state); end
    $display("test_ila done");
  endtask

  task automatic test_data_errors();
    apply_reset();
    bring_to_data(0);
    n_checks++; if (o_link_state !== 4'b1000) begin n_fail++; $display("FAIL data_enter: got %b want 1000", o_link_state); end
    for (int e = 0; e < 3; e++) begin
      send_err();
      if (e < 2) begin
        n_checks++; if (o_link_state !== 4'b1000) begin n_fail++; $display("FAIL data_err_stay[%0d]: got %b want 1000", e, o_link_state); end
        repeat (2) send_d(8'($urandom));
      end
    end
    n_checks++; if (o_link_state !== 4'b0001) begin n_fail++; $display("FAIL data_trip: got %b want 0001", o_link_state); end
    n_checks++; if (o_data_valid !== 1'b0) begin n_fail++; $display("FAIL data_trip_dv: got %b want 0", o_data_valid); end
    n_checks++; if (o_err_cnt !== 8'd3) begin n_fail++; $display("FAIL data_trip_cnt: got %0d want 3", o_err_cnt); end
    idle();
    n_checks++; if (o_sync_n !== 1'b0) begin n_fail++; $display("FAIL data_trip_sync: got %b want 0", o_sync_n); end

    apply_reset();
    bring_to_data(1);
    repeat (2) send_err();
    repeat (4) send_d(8'($urandom));
    repeat (2) send_err();
    n_checks++; if (o_link_state !== 4'b1000) begin n_fail++; $display("FAIL data_clean_clear: got %b want 1000", o_link_state); end
    n_checks++; if (o_err_cnt !== 8'd4) begin n_fail++; $display("FAIL data_cnt4: got %0d want 4", o_err_cnt); end
    repeat (4) send_d(8'($urandom));
    g_clr = 1'b1;
    send_err();
    n_checks++; if (o_err_cnt !== 8'd0) begin n_fail++; $display("FAIL data_clr_wins: got %0d want 0", o_err_cnt); end
    repeat (4) send_d(8'($urandom));
    for (int i = 0; i < 300; i++) begin
      send_err();
      repeat (4) send_d(8'($urandom));
      if (i == 253) begin
        n_checks++; if (o_err_cnt !== 8'd254) begin n_fail++; $display("FAIL data_cnt254: got %0d want 254", o_err_cnt); end
      end
    end
    n_checks++; if (o_err_cnt !== 8'd255) begin n_fail++; $display("FAIL data_saturate: got %0d want 255", o_err_cnt); end
    n_checks++; if (o_link_state !== 4'b1000) begin n_fail++; $display("FAIL data_spaced_stay: got %b want 1000", o_link_state); end
    $display("test_data_errors done");
  endtask

  task automatic test_resync();
    apply_reset();
    bring_to_ila(255);
    send_k(K28_0);
    repeat (5) send_k(K28_3);
    n_checks++; if (o_link_state !== 4'b0100) begin n_fail++; $display("FAIL resync_ila256: got %b want 0100", o_link_state); end
    g_rs = 1'b1;
    send_k(K28_3);
    n_checks++; if (o_link_state !== 4'b0001) begin n_fail++; $display("FAIL resync_ila: got %b want 0001", o_link_state); end
    idle();
    n_checks++; if (o_sync_n !== 1'b0) begin n_fail++; $display("FAIL resync_sync: got %b want 0", o_sync_n); end
    i_ila_multiframe_length = 8'd0;
    repeat (3) send_k(K28_5);
    n_checks++; if (o_link_state !== 4'b0001) begin n_fail++; $display("FAIL resync_cgs_cleared: got %b want 0001", o_link_state); end
    send_k(K28_5);
    g_lmfc = 1'b1;
    idle();
    send_k(K28_0);
    send_k(K28_3);
    n_checks++; if (o_link_state !== 4'b1000) begin n_fail++; $display("FAIL resync_relink: got %b want 1000", o_link_state); end
    g_rs = 1'b1;
    send_d(8'hA5);
    n_checks++; if (o_link_state !== 4'b0001 || o_data_valid !== 1'b0) begin n_fail++; $display("FAIL resync_data: state %b dv %b want 0001/0", o_link_state, o_data_valid); end
    $display("test_resync done");
  endtask

  task automatic test_async_reset();
    apply_reset();
    bring_to_data(0);
    send_err();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (o_link_state !== 4'b0001) begin n_fail++; $display("FAIL async_state: got %b want 0001", o_link_state); end
    n_checks++; if (o_sync_n !== 1'b0 || o_data_valid !== 1'b0) begin n_fail++; $display("FAIL async_outputs: sync %b dv %b want 0/0", o_sync_n, o_data_valid); end
    n_checks++; if (o_err_cnt !== 8'd0 || o_data !== 8'd0) begin n_fail++; $display("FAIL async_regs: cnt %0d data %h want 0/00", o_err_cnt, o_data); end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) send_k(K28_5);
    n_checks++; if (o_link_state !== 4'b0010) begin n_fail++; $display("FAIL async_restart: got %b want 0010", o_link_state); end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int         p;
    logic       v, k, de, nit;
    logic [7:0] oct;
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      i_ila_multiframe_length = 8'($urandom_range(0, 3));
      for (int c = 0; c < 600; c++) begin
        p = $urandom_range(0, 99);
        v = 1'b1; k = 1'b0; de = 1'b0; nit = 1'b0; oct = 8'($urandom);
        if (p < 40) begin k = 1'b1; oct = K28_5; end
        else if (p < 55) begin k = 1'b1; oct = K28_0; end
        else if (p < 75) begin k = 1'b1; oct = K28_3; end
        else if (p < 78) begin de = 1'($urandom); nit = !de; k = 1'($urandom); end
        else if (p >= 90) v = 1'b0;
        g_lmfc = ($urandom_range(0, 7) == 0);
        g_fclk = ($urandom_range(0, 3) == 0);
        g_rs   = ($urandom_range(0, 299) == 0);
        g_clr  = ($urandom_range(0, 149) == 0);
        tick(v, oct, k, de, nit);
        n_checks++; if (o_link_state !== phase_onehot(m_st)) begin n_fail++; $display("FAIL rnd_state[%0d.%0d]: got %b want %b", r, c, o_link_state, phase_onehot(m_st)); end
        n_checks++; if (o_sync_n !== exp_sync) begin n_fail++; $display("FAIL rnd_sync[%0d.%0d]: got %b want %b", r, c, o_sync_n, exp_sync); end
        n_checks++; if (o_data_valid !== exp_dv) begin n_fail++; $display("FAIL rnd_dv[%0d.%0d]: got %b want %b", r, c, o_data_valid, exp_dv); end
        n_checks++; if (o_data !== exp_data) begin n_fail++; $display("FAIL rnd_data[%0d.%0d]: got %h want %h", r, c, o_data, exp_data); end
        n_checks++; if (o_err_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL rnd_err_cnt[%0d.%0d]: got %0d want %0d", r, c, o_err_cnt, m_cnt); end
        n_checks++; if (o_ila_frame_cnt !== 8'(m_frame)) begin n_fail++; $display("FAIL rnd_frame[%0d.%0d]: got %0d want %0d", r, c, o_ila_frame_cnt, m_frame); end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_cgs();
    test_ila();
    test_data_errors();
    test_resync();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_control.md
RX_CONTROL -- requirements
Module: rx_control

Interface
REQ-001 clk  in  1  device clock; all logic on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 frame_clk  in  1  one-clk pulse at each frame boundary (clk domain).
REQ-004 lmfc_clk  in  1  one-clk pulse at each LMFC boundary (clk domain).
REQ-005 i_valid  in  1  decoded octet valid this cycle.
REQ-006 i_octet  in  8  decoded octet from 8b/10b decoder.
REQ-007 i_is_k  in  1  octet is a control character.
REQ-008 i_disp_err  in  1  running-disparity error on this octet.
REQ-009 i_nit_err  in  1  not-in-table error on this octet.
REQ-010 i_ila_multiframe_length  in  8  ILA length in multiframes, encoded value-1 (1..256).
REQ-011 i_reg_resync  in  1  software-forced link re-initialization.
REQ-012 i_err_cnt_clr  in  1  clears o_err_cnt.
REQ-013 o_sync_n  out  1  SYNC~ to transmitter; 0 = request synchronization.
REQ-014 o_link_state  out  4  one-hot FSM state.
REQ-015 o_data  out  8  registered user octet.
REQ-016 o_data_valid  out  1  o_data valid (DATA state only).
REQ-017 o_err_cnt  out  8  saturating count of errored octets in DATA.

Function
REQ-018 FSM states SHALL be CS_INIT=4'b0001, CS_WAIT=4'b0010, ILA=4'b0100, DATA=4'b1000; o_link_state equals current state.
REQ-019 "Good /K/" = i_valid & i_is_k & i_octet==8'hBC & !i_disp_err & !i_nit_err; "errored" = i_valid & (i_disp_err | i_nit_err).
REQ-020 CS_INIT: 3-bit consecutive good-/K/ counter; any other valid octet clears it; 4th good /K/ -> CS_WAIT next cycle; counter cleared on leaving.
REQ-021 CS_WAIT: on lmfc_clk -> ILA; lmfc_clk in the same cycle as the 4th /K/ SHALL NOT count (boundary wait starts the cycle after entry).
REQ-022 ILA: good /K/ ignored; first other valid octet must be /R/ (K, 8'h1C), else -> CS_INIT; each /A/ (K, 8'h7C) increments 9-bit multiframe counter.
REQ-023 ILA exit: when counter reaches i_ila_multiframe_length+1 (9-bit arithmetic, 256 supported) -> DATA next cycle; any errored octet in ILA -> CS_INIT.
REQ-024 DATA: 2-bit error counter increments on errored octet; 4 consecutive clean valid octets clear it; reaching 3 -> CS_INIT next cycle.
REQ-025 o_sync_n SHALL be registered: 0 in CS_INIT/CS_WAIT, 1 in ILA/DATA, 1-cycle latency from state change.
REQ-026 o_data/o_data_valid SHALL register i_octet/i_valid with 1-cycle latency, o_data_valid forced 0 outside DATA; octet causing DATA->CS_INIT is not presented.
REQ-027 o_err_cnt increments per errored octet in DATA, saturates at 255; i_err_cnt_clr wins over simultaneous increment.
REQ-028 i_reg_resync SHALL force CS_INIT from any state next cycle, overriding all other transitions, and clear all FSM counters.
REQ-029 frame_clk SHALL only be used for an ILA frame counter exposed as debug; it SHALL NOT gate transitions.

Reset
REQ-030 On rst_n low: state CS_INIT, o_sync_n=0, o_data=0, o_data_valid=0, o_err_cnt=0, all internal counters 0.
REQ-031 Reset mid-operation SHALL abort ILA/DATA immediately (asynchronous), restarting CGS after release.

Structure
REQ-032 Package jesd_rx_pkg SHALL hold state encodings, K constants (K28.5 8'hBC, K28.0 8'h1C, K28.3 8'h7C, K28.4 8'h9C), CGS threshold 4, error threshold 3.
REQ-033 DATA-state error counting (REQ-024, REQ-027) SHALL be sub-module rx_err_monitor; FSM stays in rx_control.

Verification
REQ-034 Reset, then 4 good /K/ -> CS_WAIT; lmfc_clk 10 cycles later -> o_sync_n=1 next cycle.
REQ-035 3 /K/, one data octet 8'h55, 4 /K/ -> CS_WAIT only after the second run.
REQ-036 length=8'd3: /R/, 4x /A/-terminated multiframes -> DATA after 4th /A/; o_data_valid follows i_valid by 1 cycle.
REQ-037 DATA: 3 errored octets separated by 2 clean octets -> CS_INIT, o_sync_n=0; o_err_cnt=3.
REQ-038 DATA: 2 errors, 4 clean, 2 errors -> stays DATA; 300 errored octets (spaced) -> o_err_cnt=255.
REQ-039 i_reg_resync during ILA with i_ila_multiframe_length=8'd255 -> CS_INIT next cycle, counters 0.
